// File: rtl/security_fifo_sequencer.sv
// Strobe sequencer for the three-FIFO security datapath: load FIFO2 from the host,
// move FIFO2->FIFO1->FIFO3, then drain FIFO3 to the host. Control only; no data path.
module security_fifo_sequencer #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 4,
  parameter int XFER_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_strobe,
  output logic             wr1,
  output logic             rd1,
  output logic             wr2,
  output logic             rd2,
  output logic             wr3,
  output logic             rd3,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PH_W = (XFER_LAT < 2) ? 1 : $clog2(XFER_LAT + 1);
  localparam logic [PH_W-1:0]  PH_ZERO = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(XFER_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    S1    = 3'd2,
    S2    = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     len_r, len_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [PH_W-1:0]      ph_r, ph_nxt_s;
  logic [XFER_LAT-1:0]  os_sr_r, os_nxt_s;
  logic                 last_word_s;
  logic                 done_nxt_s, err_nxt_s;

  // Unregistered handshake decodes
  assign in_ready   = (state_r == LOAD);
  assign wr2        = in_ready & in_valid;
  assign rd3        = (state_r == DRAIN) & out_ready & (cnt_r < len_r);
  assign out_strobe = os_sr_r[XFER_LAT-1];
  assign last_word_s = ((cnt_r + CNT_ONE) == len_r);

  // Next-state, counter, phase and out_strobe pipeline decode
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    cnt_nxt_s   = cnt_r;
    ph_nxt_s    = ph_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    os_nxt_s    = os_sr_r << 1;
    os_nxt_s[0] = rd3;
    case (state_r)
      IDLE: begin
        if (start && (len != CNT_ZERO) && (len <= CNT_MAX)) begin
          state_nxt_s = LOAD;
          len_nxt_s   = len;
          cnt_nxt_s   = CNT_ZERO;
        end else if (start) begin
          err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (wr2 && last_word_s) begin
          state_nxt_s = S1;
          cnt_nxt_s   = CNT_ZERO;
          ph_nxt_s    = PH_ZERO;
        end else if (wr2) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      // Each word takes XFER_LAT+1 cycles: rd at phase 0, wr at phase XFER_LAT
      S1, S2: begin
        if (ph_r == PH_LAST) begin
          ph_nxt_s = PH_ZERO;
          if (last_word_s) begin
            state_nxt_s = (state_r == S1) ? S2 : DRAIN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          ph_nxt_s = ph_r + PH_ONE;
        end
      end
      DRAIN: begin
        if (rd3) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if ((cnt_nxt_s == len_r) && (os_nxt_s == {XFER_LAT{1'b0}})) begin
          state_nxt_s = FIN;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (abort && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
      ph_nxt_s    = PH_ZERO;
      os_nxt_s    = {XFER_LAT{1'b0}};
      done_nxt_s  = 1'b0;
    end else begin
      os_nxt_s = os_nxt_s;
    end
  end

  // State, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      len_r   <= CNT_ZERO;
      cnt_r   <= CNT_ZERO;
      ph_r    <= PH_ZERO;
      os_sr_r <= {XFER_LAT{1'b0}};
      rd2     <= 1'b0;
      wr1     <= 1'b0;
      rd1     <= 1'b0;
      wr3     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ph_r    <= ph_nxt_s;
      os_sr_r <= os_nxt_s;
      rd2     <= (state_nxt_s == S1) && (ph_nxt_s == PH_ZERO);
      wr1     <= (state_nxt_s == S1) && (ph_nxt_s == PH_LAST);
      rd1     <= (state_nxt_s == S2) && (ph_nxt_s == PH_ZERO);
      wr3     <= (state_nxt_s == S2) && (ph_nxt_s == PH_LAST);
      busy    <= (state_nxt_s != IDLE);
      done    <= done_nxt_s;
      err     <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_security_fifo_sequencer.sv
// Directed bench for security_fifo_sequencer: cycle-exact strobe traces for XFER_LAT=1 and 3,
// bad lengths, stalls, reset/abort mid-frame and start while busy.
module tb_security_fifo_sequencer;

  localparam int CW = 4;
  localparam int ER = 0, DN = 1, BZ = 2, R3 = 3, W3 = 4, R2 = 5, W2 = 6, R1 = 7, W1 = 8, OS = 9, IR = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] len = 4'd0;

  logic in_ready, out_strobe, wr1, rd1, wr2, rd2, wr3, rd3, busy, done, err;
  logic in_ready3, out_strobe3, wr1_3, rd1_3, wr2_3, rd2_3, wr3_3, rd3_3, busy3, done3, err3;
  logic [10:0] obs, obs3;

  int checks = 0;
  int fails = 0;
  int onehot_viol = 0;
  logic [31:0] tr [11];
  logic [31:0] tr3 [11];
  string nm [11] = '{"err", "done", "busy", "rd3", "wr3", "rd2", "wr2", "rd1", "wr1", "out_strobe", "in_ready"};

  security_fifo_sequencer #(.DEPTH(8), .CNT_W(CW), .XFER_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready), .out_strobe(out_strobe),
    .wr1(wr1), .rd1(rd1), .wr2(wr2), .rd2(rd2), .wr3(wr3), .rd3(rd3),
    .busy(busy), .done(done), .err(err)
  );

  security_fifo_sequencer #(.DEPTH(8), .CNT_W(CW), .XFER_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready3), .out_ready(out_ready), .out_strobe(out_strobe3),
    .wr1(wr1_3), .rd1(rd1_3), .wr2(wr2_3), .rd2(rd2_3), .wr3(wr3_3), .rd3(rd3_3),
    .busy(busy3), .done(done3), .err(err3)
  );

  assign obs  = {in_ready, out_strobe, wr1, rd1, wr2, rd2, wr3, rd3, busy, done, err};
  assign obs3 = {in_ready3, out_strobe3, wr1_3, rd1_3, wr2_3, rd2_3, wr3_3, rd3_3, busy3, done3, err3};

  always #5 clk = ~clk;

  task automatic cyc(input logic st, input logic [CW-1:0] l, input logic iv, input logic ordy, input logic ab);
    @(posedge clk);
    #1;
    start = st; len = l; in_valid = iv; out_ready = ordy; abort = ab;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; len = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle k of the trace is the k-th clock after the call; bit k of each trace word is that output
  task automatic run_trace(input int n, input logic [31:0] st_pat, input logic [CW-1:0] l,
                           input logic [31:0] iv_pat, input logic [31:0] or_pat);
    for (int i = 0; i < 11; i++) begin
      tr[i] = 32'h0;
      tr3[i] = 32'h0;
    end
    for (int k = 0; k < n; k++) begin
      cyc(st_pat[k], l, iv_pat[k], or_pat[k], 1'b0);
      for (int i = 0; i < 11; i++) begin
        tr[i][k]  = obs[i];
        tr3[i][k] = obs3[i];
      end
      if ($countones(obs[8:3]) > 1 || $countones(obs3[8:3]) > 1) onehot_viol++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] any_s;
    #3;
    checks++;
    if (obs !== 11'h0) begin $display("FAIL reset_outputs got %h exp %h", obs, 11'h0); fails++; end
    checks++;
    if (obs3 !== 11'h0) begin $display("FAIL reset_outputs_lat3 got %h exp %h", obs3, 11'h0); fails++; end
    apply_reset();
    run_trace(4, 32'h0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    any_s = 32'h0;
    for (int i = 0; i < 11; i++) any_s = any_s | tr[i];
    checks++;
    if (any_s !== 32'h0) begin $display("FAIL idle_ignores_handshake got %h exp %h", any_s, 32'h0); fails++; end
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_s [11];
    exp_s = '{32'h0, 32'h4000, 32'h7FFE, 32'h1800, 32'h500, 32'h28, 32'h6, 32'h280, 32'h50, 32'h3000, 32'h6};
    apply_reset();
    onehot_viol = 0;
    run_trace(16, 32'h1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (tr[i] !== exp_s[i]) begin $display("FAIL basic_%s got %h exp %h", nm[i], tr[i], exp_s[i]); fails++; end
    end
    checks++;
    if (onehot_viol !== 0) begin $display("FAIL basic_onehot got %0d exp 0", onehot_viol); fails++; end
  endtask

  task automatic test_bad_len();
    logic [31:0] strb_s;
    logic [CW-1:0] bad_s [2];
    bad_s = '{4'd0, 4'd9};
    apply_reset();
    for (int j = 0; j < 2; j++) begin
      run_trace(3, 32'h1, bad_s[j], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      strb_s = tr[W1] | tr[R1] | tr[W2] | tr[R2] | tr[W3] | tr[R3] | tr[OS] | tr[IR];
      checks++;
      if (tr[ER] !== 32'h2) begin $display("FAIL badlen%0d_err got %h exp %h", bad_s[j], tr[ER], 32'h2); fails++; end
      checks++;
      if (tr[BZ] !== 32'h0) begin $display("FAIL badlen%0d_busy got %h exp %h", bad_s[j], tr[BZ], 32'h0); fails++; end
      checks++;
      if (strb_s !== 32'h0) begin $display("FAIL badlen%0d_strobes got %h exp %h", bad_s[j], strb_s, 32'h0); fails++; end
    end
  endtask

  task automatic test_gappy_flow();
    apply_reset();
    onehot_viol = 0;
    run_trace(30, 32'h1, 4'd3, 32'hAAAA_AAAA, 32'hFFE7_FFFF);
    for (int i = R3; i <= OS; i++) begin
      checks++;
      if ($countones(tr[i]) !== 3) begin $display("FAIL gappy_count_%s got %0d exp 3", nm[i], $countones(tr[i])); fails++; end
    end
    checks++;
    if (tr[R3] !== 32'h0064_0000) begin $display("FAIL gappy_rd3_timing got %h exp %h", tr[R3], 32'h0064_0000); fails++; end
    checks++;
    if (tr[DN] !== 32'h0100_0000) begin $display("FAIL gappy_done got %h exp %h", tr[DN], 32'h0100_0000); fails++; end
    checks++;
    if (onehot_viol !== 0) begin $display("FAIL gappy_onehot got %0d exp 0", onehot_viol); fails++; end
  endtask

  task automatic test_xfer_lat3();
    logic [31:0] exp_s [11];
    exp_s = '{32'h0, 32'h0100_0000, 32'h01FF_FFFE, 32'h0018_0000, 32'h0004_4000, 32'h88,
              32'h6, 32'h8800, 32'h440, 32'h00C0_0000, 32'h6};
    apply_reset();
    run_trace(28, 32'h1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (tr3[i] !== exp_s[i]) begin $display("FAIL lat3_%s got %h exp %h", nm[i], tr3[i], exp_s[i]); fails++; end
    end
  endtask

  task automatic test_reset_and_abort();
    apply_reset();
    cyc(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    checks++;
    if (wr1 !== 1'b1) begin $display("FAIL rst_pre_wr1 got %b exp %b", wr1, 1'b1); fails++; end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 11'h0) begin $display("FAIL rst_mid_s1 got %h exp %h", obs, 11'h0); fails++; end
    checks++;
    if (obs3 !== 11'h0) begin $display("FAIL rst_mid_s1_lat3 got %h exp %h", obs3, 11'h0); fails++; end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd2, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rd1 !== 1'b1) begin $display("FAIL abort_pre_rd1 got %b exp %b", rd1, 1'b1); fails++; end
    cyc(1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 11'h0) begin $display("FAIL abort_idle got %h exp %h", obs, 11'h0); fails++; end
    run_trace(10, 32'h0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ((tr[DN] | tr[BZ]) !== 32'h0) begin $display("FAIL abort_no_done got %h exp %h", tr[DN] | tr[BZ], 32'h0); fails++; end
  endtask

  task automatic test_start_in_drain();
    apply_reset();
    run_trace(20, 32'h0001_0801, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (tr[BZ] !== 32'h000E_7FFE) begin $display("FAIL drain_start_busy got %h exp %h", tr[BZ], 32'h000E_7FFE); fails++; end
    checks++;
    if (tr[DN] !== 32'h4000) begin $display("FAIL drain_start_done got %h exp %h", tr[DN], 32'h4000); fails++; end
    checks++;
    if (tr[ER] !== 32'h0) begin $display("FAIL drain_start_err got %h exp %h", tr[ER], 32'h0); fails++; end
    checks++;
    if (tr[W2] !== 32'h0006_0006) begin $display("FAIL drain_start_wr2 got %h exp %h", tr[W2], 32'h0006_0006); fails++; end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_len();
    test_gappy_flow();
    test_xfer_lat3();
    test_reset_and_abort();
    test_start_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
